lcd_char_seq: RTL and testbench
===============================

# lcd_char_seq

Upstream feeder for the LCD write stage (the custom-instruction block driving `rs`/`data`/`enable`). Accepts characters into a small FIFO, runs the HD44780 power-on command sequence, and issues one write at a time to the downstream stage over its `iniciar`/`done` handshake. Tracks the cursor and inserts DDRAM-address commands for line wrap and newline, so software or game logic can push plain text.

## Interface
- `FIFO_DEPTH`, 16: character FIFO entries; power of 2, ≥2.
- `COLS`, 16: characters per display line; 1..40.
- `clk` in 1: system clock; downstream `clk_en` is tied high.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `wr_data` into FIFO this cycle.
- `wr_data` in 8: character code.
- `clr` in 1: single-cycle request to clear the screen and home the cursor.
- `full` out 1: FIFO full.
- `level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; push attempted while full.
- `init_done` out 1: power-on sequence complete.
- `iniciar` out 1: single-cycle start pulse to downstream.
- `dataA` out 32: bit0 = rs (0 command, 1 data); bits 31:1 always 0.
- `dataB` out 32: bits 7:0 byte to write; bits 31:8 always 0.
- `done` in 1: downstream completion pulse.

## Operation
- States: INIT, IDLE, WAIT.
- INIT: issues commands 0x38, 0x0C, 0x01, 0x06 in order (rs=0), each via issue→WAIT→back; after 0x06's `done`, `init_done`=1, go IDLE. FIFO accepts pushes during INIT.
- Issue: drive `dataA`/`dataB`, pulse `iniciar` for exactly one cycle, enter WAIT; `dataA`/`dataB` held stable until `done` seen.
- WAIT: ignore everything except `done` (and `clr` latch); on `done`, return to the issuing state (INIT or IDLE).
- IDLE priority: pending clear > pending address command > FIFO head.
- Clear: issue 0x01; col=0, row=0, need_addr=0; flush FIFO; clear `overflow`. `clr` arriving during INIT or WAIT is latched and served at next IDLE.
- Char write (head not 0x0A): if need_addr, issue 0x80|(row?0x40:0x00) first, clear need_addr, char stays at head. Otherwise pop, issue rs=1 with char; col++. If col reaches COLS: col=0, row^=1, need_addr=1.
- Newline 0x0A: pop, no downstream write; col=0, row^=1, need_addr=1.
- FIFO: push when `full` ignored and sets `overflow`; simultaneous push and pop allowed when not full (level unchanged); push into empty FIFO with pop impossible same cycle.
- Only 2 rows supported; row wraps 1→0.

## Timing
- Reset values: `full`=0, `level`=0, `overflow`=0, `init_done`=0, `iniciar`=0, `dataA`=0, `dataB`=0; state INIT, col=row=0, need_addr=0, FIFO empty.
- First `iniciar` (dataB=0x38) on first rising edge after `reset` deasserts.
- Next issue no earlier than the cycle after `done` is sampled (≥1 idle cycle between writes).
- Char pushed at edge N into empty FIFO, in IDLE with nothing pending: `iniciar` asserted after edge N+1.
- `done` asserted while not in WAIT is ignored.
- `reset` asserted mid-operation: all outputs to reset values immediately; FIFO contents lost; restart INIT.
- `level`, `full` update on the edge of the push/pop.

## Configuration
- `LCD_CHAR_SEQ_WRAP_EN` defined: cursor tracking, address insertion, newline handling as above.
- Not defined: no col/row tracking, no address commands; every FIFO byte including 0x0A written as rs=1 data; `clr` still issues 0x01 and flushes FIFO.

## Test plan
- Reset release, `done` returned 5 cycles after each `iniciar` -> writes 0x38, 0x0C, 0x01, 0x06 (rs=0), then `init_done`=1.
- Push "AB" after init -> writes rs=1 0x41 then 0x42; `level` 2→0; no command between.
- COLS=16, push 17 × 0x41 -> 16 data writes, command 0xC0, 17th data write.
- Push 0x41, 0x0A, 0x42 -> data 0x41, command 0xC0, data 0x42; 0x0A never written.
- Fill FIFO while `done` withheld, push one more -> `full`=1, `overflow`=1, level=16; pulse `clr` -> after current `done`, command 0x01, level=0, `overflow`=0.
- Assert `reset` during WAIT -> `iniciar`=0, `dataB`=0 immediately; after release, 0x38 reissued.

Source files
------------

// File: rtl/lcd_char_seq.sv
// lcd_char_seq: character FIFO plus HD44780 init/command sequencer feeding the LCD write stage.
// Define LCD_CHAR_SEQ_WRAP_EN to enable cursor tracking, line-wrap addressing and newline handling.
module lcd_char_seq #(
    parameter int FIFO_DEPTH = 16,
    parameter int COLS       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        clr,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        init_done,
    output logic                        iniciar,
    output logic [31:0]                 dataA,
    output logic [31:0]                 dataB,
    input  logic                        done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, WAIT} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          flush;
    logic          serve_clear;
    logic          serve_char;
    logic          clr_pending;
    logic [2:0]    cmd_idx;
    logic          rs_q;
    logic [7:0]    byte_q;
`ifdef LCD_CHAR_SEQ_WRAP_EN
    logic [5:0]    col;
    logic          row;
    logic          need_addr;
    logic          serve_addr;
    logic          serve_nl;
`endif

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign level = count;
    assign head  = mem[rd_ptr];
    assign dataA = {31'd0, rs_q};
    assign dataB = {24'd0, byte_q};

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // IDLE arbitration: pending clear, then pending address command, then the FIFO head.
    always_comb begin
        serve_clear = 1'b0;
        serve_char  = 1'b0;
`ifdef LCD_CHAR_SEQ_WRAP_EN
        serve_addr  = 1'b0;
        serve_nl    = 1'b0;
`endif
        if (state == IDLE) begin
            if (clr_pending) begin
                serve_clear = 1'b1;
            end
`ifdef LCD_CHAR_SEQ_WRAP_EN
            else if (need_addr) begin
                serve_addr = 1'b1;
            end else if (count != '0) begin
                if (head == 8'h0A) begin
                    serve_nl = 1'b1;
                end else begin
                    serve_char = 1'b1;
                end
            end
`else
            else if (count != '0) begin
                serve_char = 1'b1;
            end
`endif
        end
    end

`ifdef LCD_CHAR_SEQ_WRAP_EN
    assign pop = serve_char | serve_nl;
`else
    assign pop = serve_char;
`endif
    assign flush = serve_clear;
    assign push  = wr_en & ~full & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A flush also drops any push landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
            if (serve_clear) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Sequencer: every downstream write is a one-cycle iniciar followed by WAIT until done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            cmd_idx     <= 3'd0;
            init_done   <= 1'b0;
            iniciar     <= 1'b0;
            rs_q        <= 1'b0;
            byte_q      <= 8'h00;
            clr_pending <= 1'b0;
`ifdef LCD_CHAR_SEQ_WRAP_EN
            col         <= 6'd0;
            row         <= 1'b0;
            need_addr   <= 1'b0;
`endif
        end else begin
            iniciar <= 1'b0;
            if (clr) begin
                clr_pending <= 1'b1;
            end
            case (state)
                INIT: begin
                    rs_q    <= 1'b0;
                    byte_q  <= init_cmd(cmd_idx);
                    iniciar <= 1'b1;
                    cmd_idx <= cmd_idx + 3'd1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        if (init_done) begin
                            state <= IDLE;
                        end else if (cmd_idx == 3'd4) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= INIT;
                        end
                    end
                end
                IDLE: begin
                    if (serve_clear) begin
                        rs_q        <= 1'b0;
                        byte_q      <= 8'h01;
                        iniciar     <= 1'b1;
                        state       <= WAIT;
                        clr_pending <= clr;
`ifdef LCD_CHAR_SEQ_WRAP_EN
                        col         <= 6'd0;
                        row         <= 1'b0;
                        need_addr   <= 1'b0;
`endif
                    end
`ifdef LCD_CHAR_SEQ_WRAP_EN
                    else if (serve_addr) begin
                        rs_q      <= 1'b0;
                        byte_q    <= {1'b1, row, 6'd0};
                        iniciar   <= 1'b1;
                        need_addr <= 1'b0;
                        state     <= WAIT;
                    end else if (serve_nl) begin
                        col       <= 6'd0;
                        row       <= ~row;
                        need_addr <= 1'b1;
                    end
`endif
                    else if (serve_char) begin
                        rs_q    <= 1'b1;
                        byte_q  <= head;
                        iniciar <= 1'b1;
                        state   <= WAIT;
`ifdef LCD_CHAR_SEQ_WRAP_EN
                        if (col == 6'(COLS - 1)) begin
                            col       <= 6'd0;
                            row       <= ~row;
                            need_addr <= 1'b1;
                        end else begin
                            col <= col + 6'd1;
                        end
`endif
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_seq.sv
// tb_lcd_char_seq: directed and randomized checks of lcd_char_seq against a text-level cursor model.
// Honours LCD_CHAR_SEQ_WRAP_EN the same way the design does.
module tb_lcd_char_seq;

    localparam int FIFO_DEPTH = 16;
    localparam int COLS       = 16;
    localparam int DONE_DLY   = 5;

    logic                        clk;
    logic                        reset;
    logic                        wr_en;
    logic [7:0]                  wr_data;
    logic                        clr;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        overflow;
    logic                        init_done;
    logic                        iniciar;
    logic [31:0]                 dataA;
    logic [31:0]                 dataB;
    logic                        done;

    int         checks    = 0;
    int         errors    = 0;
    bit         hold_done = 0;
    int         pend      = -1;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
`ifdef LCD_CHAR_SEQ_WRAP_EN
    int         m_col     = 0;
    int         m_row     = 0;
`endif

    lcd_char_seq #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .COLS       (COLS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr       (clr),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .init_done (init_done),
        .iniciar   (iniciar),
        .dataA     (dataA),
        .dataB     (dataB),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: the text as a display would lay it out, one entry per downstream write {rs, byte}.
    task automatic model_byte(input logic [7:0] b);
`ifdef LCD_CHAR_SEQ_WRAP_EN
        if (b == 8'h0A) begin
            m_col = 0;
            m_row = 1 - m_row;
            exp_q.push_back({1'b0, (m_row != 0) ? 8'hC0 : 8'h80});
        end else begin
            exp_q.push_back({1'b1, b});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = 1 - m_row;
                exp_q.push_back({1'b0, (m_row != 0) ? 8'hC0 : 8'h80});
            end
        end
`else
        exp_q.push_back({1'b1, b});
`endif
    endtask

    task automatic model_home();
`ifdef LCD_CHAR_SEQ_WRAP_EN
        m_col = 0;
        m_row = 0;
`endif
    endtask

    task automatic model_init();
        model_home();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    // Downstream stand-in: done pulses DONE_DLY cycles after iniciar unless held.
    initial begin : responder
        done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            if (!reset) begin
                pend = -1;
            end else if (iniciar) begin
                pend = DONE_DLY;
            end else if (pend > 0) begin
                if (!hold_done) pend--;
            end else if (pend == 0 && !hold_done) begin
                done = 1'b1;
                pend = -1;
            end
        end
    end

    // Records every write and checks the handshake rules around it.
    initial begin : monitor
        bit          busy;
        bit          gap;
        logic [31:0] la;
        logic [31:0] lb;
        busy = 0;
        gap  = 0;
        la   = '0;
        lb   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0;
                gap  = 0;
            end else begin
                if (gap) begin
                    check_output("issue_gap", 32'(iniciar), 32'd0);
                    gap = 0;
                end
                if (busy) begin
                    check_output("held_dataA", dataA, la);
                    check_output("held_dataB", dataB, lb);
                end
                if (iniciar) begin
                    check_output("iniciar_while_busy", 32'(busy), 32'd0);
                    check_output("dataA_upper", 32'(dataA[31:1]), 32'd0);
                    check_output("dataB_upper", 32'(dataB[31:8]), 32'd0);
                    got_q.push_back({dataA[0], dataB[7:0]});
                    la   = dataA;
                    lb   = dataB;
                    busy = 1;
                end else if (busy && done) begin
                    busy = 0;
                    gap  = 1;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] b, input bit modelled, input bit wait_room);
        int guard = 0;
        if (wait_room) begin
            while (full && guard < 2000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check_output("push_room", 32'(full), 32'd0);
        end
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (modelled) model_byte(b);
    endtask

    task automatic pulse_clr(input bit modelled);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        if (modelled) begin
            exp_q.push_back(9'h001);
            model_home();
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_init();
        int guard = 0;
        while (!init_done && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_output("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int guard = 0;
        while (quiet < 4 && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
            if (iniciar || pend >= 0 || done || level != 0) quiet = 0;
            else quiet++;
        end
        check_output("quiet_reached", 32'(quiet), 32'd4);
    endtask

    task automatic compare_writes(input string tag);
        check_output({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_output($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin : stimulus
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr     = 1'b0;
        step(3);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_level", 32'(level), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_init_done", 32'(init_done), 32'd0);
        check_output("rst_iniciar", 32'(iniciar), 32'd0);
        check_output("rst_dataA", dataA, 32'd0);
        check_output("rst_dataB", dataB, 32'd0);

        reset = 1'b1;
        step(1);
        check_output("first_iniciar", 32'(iniciar), 32'd1);
        check_output("first_dataA", dataA, 32'd0);
        check_output("first_dataB", dataB, 32'h38);
        model_init();
        wait_init();
        step(2);
        compare_writes("init");

        apply_stimulus(8'h41, 1, 1);
        check_output("A_level_after_push", 32'(level), 32'd1);
        check_output("A_no_issue_yet", 32'(iniciar), 32'd0);
        step(1);
        check_output("A_iniciar", 32'(iniciar), 32'd1);
        check_output("A_dataA", dataA, 32'd1);
        check_output("A_dataB", dataB, 32'h41);
        check_output("A_level_after_pop", 32'(level), 32'd0);
        apply_stimulus(8'h42, 1, 1);
        check_output("B_level_queued", 32'(level), 32'd1);
        wait_quiet();
        check_output("AB_level_drained", 32'(level), 32'd0);
        compare_writes("AB");

        pulse_clr(1);
        wait_quiet();
        for (int i = 0; i < 17; i++) apply_stimulus(8'h41, 1, 1);
        wait_quiet();
        compare_writes("wrap17");

        pulse_clr(1);
        wait_quiet();
        apply_stimulus(8'h41, 1, 1);
        apply_stimulus(8'h0A, 1, 1);
        apply_stimulus(8'h42, 1, 1);
        wait_quiet();
        compare_writes("newline");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
            apply_stimulus(b, 1, 1);
            if ($urandom_range(0, 2) == 0) step(int'($urandom_range(1, 12)));
        end
        wait_quiet();
        compare_writes("random");

        pulse_clr(1);
        wait_quiet();
        compare_writes("clr_before_fill");
        hold_done = 1;
        apply_stimulus(8'h58, 1, 1);
        step(3);
        check_output("held_level", 32'(level), 32'd0);
        for (int i = 0; i < FIFO_DEPTH; i++) apply_stimulus(8'(97 + i), 0, 0);
        check_output("fill_full", 32'(full), 32'd1);
        check_output("fill_level", 32'(level), 32'(FIFO_DEPTH));
        check_output("fill_no_overflow", 32'(overflow), 32'd0);
        apply_stimulus(8'h7A, 0, 0);
        check_output("ovf_flag", 32'(overflow), 32'd1);
        check_output("ovf_level", 32'(level), 32'(FIFO_DEPTH));
        pulse_clr(1);
        step(3);
        check_output("clr_waits_for_done", 32'(level), 32'(FIFO_DEPTH));
        hold_done = 0;
        wait_quiet();
        check_output("clr_level", 32'(level), 32'd0);
        check_output("clr_overflow", 32'(overflow), 32'd0);
        check_output("clr_full", 32'(full), 32'd0);
        compare_writes("overflow_clr");

        apply_stimulus(8'h5A, 1, 1);
        step(1);
        check_output("Z_iniciar", 32'(iniciar), 32'd1);
        step(1);
        reset = 1'b0;
        #1;
        check_output("midrst_iniciar", 32'(iniciar), 32'd0);
        check_output("midrst_dataA", dataA, 32'd0);
        check_output("midrst_dataB", dataB, 32'd0);
        check_output("midrst_init_done", 32'(init_done), 32'd0);
        check_output("midrst_level", 32'(level), 32'd0);
        step(2);
        reset = 1'b1;
        step(1);
        check_output("restart_iniciar", 32'(iniciar), 32'd1);
        check_output("restart_dataB", dataB, 32'h38);
        model_init();
        wait_init();
        step(2);
        compare_writes("reset_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
